pipeline_ctrl: RTL
==================

# pipeline_ctrl

Pipeline sequencing block for the 5-stage CPU. It holds the per-stage destination bookkeeping for EXE, MEM and WB, and produces the `exe_*`/`mem_*` write-back descriptors and `forward_rs`/`forward_rt` that the hazard unit consumes. It also consumes the hazard unit's `stall` and turns it into PC/IF-DE enables and EXE bubbles. It sits beside the decode stage and also handles data-memory back-pressure, exception flush and stall statistics.

## Interface
Parameters:
- `REG_W`, 5, register-index width
- `CNT_W`, 32, statistics counter width

Ports:
- `clk` input 1: single clock, all state on rising edge
- `resetn` input 1: synchronous, active-low reset
- `de_valid` input 1: DE stage holds a real instruction
- `de_wen` input 1: DE instruction writes the register file
- `de_dest` input REG_W: DE destination register index
- `de_memread` input 1: DE instruction is a load
- `de_rs` input REG_W: DE source register rs
- `de_rt` input REG_W: DE source register rt
- `stall` input 1: load-use stall request from the hazard unit
- `mem_busy` input 1: data memory not ready; freeze whole pipeline
- `exc_flush` input 1: exception/eret redirect from WB; squash younger stages
- `pc_en` output 1: PC register may advance (combinational)
- `de_en` output 1: IF/DE register may load (combinational)
- `de_flush` output 1: IF/DE register loads a bubble (combinational)
- `forward_rs` output REG_W: equals `de_rs` (combinational)
- `forward_rt` output REG_W: equals `de_rt` (combinational)
- `exe_wen` output 1: registered, `exe_valid & exe_wen_r`
- `exe_regsrc` output REG_W: EXE destination, 0 when not valid
- `exe_memread` output 1: EXE holds a valid load
- `mem_wen` output 1: same rule for MEM
- `mem_regsrc` output REG_W: same rule for MEM
- `wb_wen` output 1: same rule for WB
- `wb_regsrc` output REG_W: same rule for WB
- `stall_cnt` output CNT_W: cycles in which a stall bubble was inserted
- `freeze_cnt` output CNT_W: cycles frozen by `mem_busy`

## Operation
- Each of EXE, MEM and WB holds `valid`, `wen_r`, `dest_r`. EXE also holds `memread_r`.
- Each cycle falls into exactly one mode. Priority is reset > flush > freeze > stall > advance.
  - Reset (`resetn`=0): all valid/wen/dest/memread cleared; counters cleared; `pc_en`=`de_en`=`de_flush`=0.
  - Flush (`exc_flush`=1): EXE/MEM/WB valid cleared next edge; `pc_en`=1; `de_en`=1; `de_flush`=1. This mode wins over `mem_busy` and `stall`.
  - Freeze (`mem_busy`=1): all stage registers hold; `pc_en`=`de_en`=0; `de_flush`=0; `freeze_cnt`+1.
  - Stall (`stall`=1): `pc_en`=`de_en`=0. EXE loads a bubble (all fields 0). MEM<=EXE and WB<=MEM. `stall_cnt`+1.
  - Advance: `pc_en`=`de_en`=1. EXE<={`de_valid`, `de_wen`, `de_dest`, `de_memread`}, MEM<=EXE, WB<=MEM.
- Output gating:
  - All `*_wen`, `*_regsrc` and `exe_memread` are forced to 0 when the stage's valid is 0.
  - A valid instruction with dest 0 reports `regsrc`=0 and keeps its own `wen`.
- Counters saturate at all-ones and never wrap.

## Timing
- Stage outputs are registered and reflect the new state one cycle after the qualifying edge.
- `pc_en`, `de_en`, `de_flush`, `forward_rs` and `forward_rt` are combinational from the current inputs, with zero latency.
- Advance: an instruction seen in DE with `de_en`=1 appears on `exe_*` next cycle, `mem_*` after 2 cycles and `wb_*` after 3.
- Stall with `stall` held N cycles:
  - N bubbles enter EXE.
  - The DE instruction enters EXE on the first edge with `stall`=0.
- `stall` and `mem_busy` both high: freeze only; no bubble; `stall_cnt` unchanged.
- Reset deasserting mid-stream: the first post-reset cycle behaves as advance, with all stages empty.
- Counters update on the same edge as the mode they count and are readable next cycle.

## Test plan
- Reset, then 4 advance cycles with `de_valid`=1, `de_wen`=1, `de_dest`=5,6,7,8. Required: `exe_regsrc`=5 at cycle 1, `mem_regsrc`=5 at cycle 2, `wb_regsrc`=5 at cycle 3; all counters 0.
- Load-use case:
  - Stimulus: load to r3 in DE, advance; next cycle `stall`=1 for 1 cycle.
  - Required during the stall: `pc_en`=`de_en`=0.
  - Required after the stall edge: `exe_wen`=0 and `exe_regsrc`=0; `mem_regsrc`=3 with `mem_wen`=1; `stall_cnt`=1.
- `mem_busy`=1 for 3 cycles with EXE/MEM/WB holding dest 4/3/2. Required: outputs stay 4/3/2 throughout; `freeze_cnt`=3; `pc_en`=0.
- `stall`=1 and `mem_busy`=1 together for 2 cycles. Required: `stall_cnt` unchanged, `freeze_cnt`+2, no bubble inserted.
- `exc_flush`=1 with all stages valid and `mem_busy`=1. Required that cycle: `de_flush`=1 and `pc_en`=1. Required next cycle: all `*_wen`=0 and all `*_regsrc`=0.
- `resetn`=0 asserted mid-stall with counters nonzero. Required next cycle: all outputs 0 and both counters 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing for the 5-stage CPU: EXE/MEM/WB destination bookkeeping,
// PC/IF-DE enables, stall bubbles, memory freeze, exception flush and stall statistics.
module pipeline_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             de_valid,
    input  logic             de_wen,
    input  logic [REG_W-1:0] de_dest,
    input  logic             de_memread,
    input  logic [REG_W-1:0] de_rs,
    input  logic [REG_W-1:0] de_rt,
    input  logic             stall,
    input  logic             mem_busy,
    input  logic             exc_flush,
    output logic             pc_en,
    output logic             de_en,
    output logic             de_flush,
    output logic [REG_W-1:0] forward_rs,
    output logic [REG_W-1:0] forward_rt,
    output logic             exe_wen,
    output logic [REG_W-1:0] exe_regsrc,
    output logic             exe_memread,
    output logic             mem_wen,
    output logic [REG_W-1:0] mem_regsrc,
    output logic             wb_wen,
    output logic [REG_W-1:0] wb_regsrc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    logic             exe_valid_q, exe_valid_d, exe_wen_q, exe_wen_d, exe_memread_q, exe_memread_d;
    logic [REG_W-1:0] exe_dest_q, exe_dest_d;
    logic             mem_valid_q, mem_valid_d, mem_wen_q, mem_wen_d;
    logic [REG_W-1:0] mem_dest_q, mem_dest_d;
    logic             wb_valid_q, wb_valid_d, wb_wen_q, wb_wen_d;
    logic [REG_W-1:0] wb_dest_q, wb_dest_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, freeze_cnt_q, freeze_cnt_d;

    // Priority: reset > flush > freeze > stall > advance.
    always_comb begin
        pc_en    = 1'b0;
        de_en    = 1'b0;
        de_flush = 1'b0;
        if (resetn) begin
            if (exc_flush) begin
                pc_en    = 1'b1;
                de_en    = 1'b1;
                de_flush = 1'b1;
            end else if (!mem_busy && !stall) begin
                pc_en = 1'b1;
                de_en = 1'b1;
            end
        end
    end

    assign forward_rs = de_rs;
    assign forward_rt = de_rt;

    always_comb begin
        exe_valid_d   = exe_valid_q;
        exe_wen_d     = exe_wen_q;
        exe_dest_d    = exe_dest_q;
        exe_memread_d = exe_memread_q;
        mem_valid_d   = mem_valid_q;
        mem_wen_d     = mem_wen_q;
        mem_dest_d    = mem_dest_q;
        wb_valid_d    = wb_valid_q;
        wb_wen_d      = wb_wen_q;
        wb_dest_d     = wb_dest_q;
        stall_cnt_d   = stall_cnt_q;
        freeze_cnt_d  = freeze_cnt_q;
        if (exc_flush) begin
            exe_valid_d = 1'b0;
            mem_valid_d = 1'b0;
            wb_valid_d  = 1'b0;
        end else if (mem_busy) begin
            if (freeze_cnt_q != '1) freeze_cnt_d = freeze_cnt_q + CNT_W'(1);
        end else begin
            wb_valid_d  = mem_valid_q;
            wb_wen_d    = mem_wen_q;
            wb_dest_d   = mem_dest_q;
            mem_valid_d = exe_valid_q;
            mem_wen_d   = exe_wen_q;
            mem_dest_d  = exe_dest_q;
            if (stall) begin
                exe_valid_d   = 1'b0;
                exe_wen_d     = 1'b0;
                exe_dest_d    = '0;
                exe_memread_d = 1'b0;
                if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end else begin
                exe_valid_d   = de_valid;
                exe_wen_d     = de_wen;
                exe_dest_d    = de_dest;
                exe_memread_d = de_memread;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            exe_valid_q   <= 1'b0;
            exe_wen_q     <= 1'b0;
            exe_dest_q    <= '0;
            exe_memread_q <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_wen_q     <= 1'b0;
            mem_dest_q    <= '0;
            wb_valid_q    <= 1'b0;
            wb_wen_q      <= 1'b0;
            wb_dest_q     <= '0;
            stall_cnt_q   <= '0;
            freeze_cnt_q  <= '0;
        end else begin
            exe_valid_q   <= exe_valid_d;
            exe_wen_q     <= exe_wen_d;
            exe_dest_q    <= exe_dest_d;
            exe_memread_q <= exe_memread_d;
            mem_valid_q   <= mem_valid_d;
            mem_wen_q     <= mem_wen_d;
            mem_dest_q    <= mem_dest_d;
            wb_valid_q    <= wb_valid_d;
            wb_wen_q      <= wb_wen_d;
            wb_dest_q     <= wb_dest_d;
            stall_cnt_q   <= stall_cnt_d;
            freeze_cnt_q  <= freeze_cnt_d;
        end
    end

    // Empty stages report nothing, regardless of stale field contents.
    assign exe_wen     = exe_valid_q & exe_wen_q;
    assign exe_regsrc  = exe_valid_q ? exe_dest_q : '0;
    assign exe_memread = exe_valid_q & exe_memread_q;
    assign mem_wen     = mem_valid_q & mem_wen_q;
    assign mem_regsrc  = mem_valid_q ? mem_dest_q : '0;
    assign wb_wen      = wb_valid_q & wb_wen_q;
    assign wb_regsrc   = wb_valid_q ? wb_dest_q : '0;
    assign stall_cnt   = stall_cnt_q;
    assign freeze_cnt  = freeze_cnt_q;

endmodule
